sirv_gnrl_skid_buf: RTL and testbench
=====================================

// Module: sirv_gnrl_skid_buf
// PURPOSE
//  2-entry valid/ready skid buffer: the drain-side counterpart to load-enable capture registers.
//  Accepts words from an upstream producer, holds them, and hands them to a downstream consumer.
//  Upstream ready is decoded from registered state, so it never depends combinationally on o_rdy.
//  Placed between pipeline stages to break the ready timing path without losing throughput.
// PARAMETERS
//  DW  32  data word width in bits
// PORTS
//  clk     in   1   clock, rising edge
//  rst_n   in   1   reset, asynchronous, active-low
//  flush   in   1   synchronous clear of buffered contents
//  i_vld   in   1   upstream word valid
//  i_rdy   out  1   buffer can accept; i_hs = i_vld & i_rdy
//  i_dat   in   DW  upstream word
//  o_vld   out  1   downstream word valid
//  o_rdy   in   1   downstream accepts; o_hs = o_vld & o_rdy
//  o_dat   out  DW  downstream word
//  o_cnt   out  2   occupancy, 0..2
// BEHAVIOUR
//  Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
//  Reset values: state=EMPTY, main/skid regs=0, o_vld=0, o_dat=0, o_cnt=0, i_rdy=1.
//  State machine, 3 states: EMPTY(cnt0), ONE(cnt1, word in main), FULL(cnt2, main=older, skid=newer).
//  i_rdy = (state!=FULL). o_vld = (state!=EMPTY). o_dat = main reg.
//  EMPTY: i_hs -> main<=i_dat, ONE.
//  ONE: i_hs&o_hs -> main<=i_dat, stay ONE.
//       i_hs only -> skid<=i_dat, FULL.
//       o_hs only -> EMPTY.
//  FULL: o_hs -> main<=skid, ONE. No input is accepted (i_rdy=0).
//  Latency: 1 cycle, i_hs to o_vld. Throughput: 1 word/cycle sustained while o_rdy=1.
//  Ordering: strict FIFO. No word is dropped or duplicated under any i_vld/o_rdy pattern.
//  flush=1: next state EMPTY regardless of handshakes. Words in flight that cycle are discarded.
//           Data regs are not cleared. i_rdy stays decoded from current state (the i_hs word is dropped).
//  Reset mid-operation: all buffered words are lost immediately (async). o_vld drops without waiting for clk.
//  Protocol rules for the environment:
//   - once i_vld=1, it holds with i_dat stable until i_hs;
//   - o_vld/o_dat from this block obey the same rule, except across flush.
//  Arithmetic: o_cnt = 2-bit state-derived count. No wrap is possible; cnt never exceeds 2.
// CONFIGURATION
//  SIRV_SKID_BYPASS_EN defined:
//   - In EMPTY with i_vld=1 and o_rdy=1: o_vld=1, o_dat=i_dat combinationally, i_hs and o_hs fire.
//   - The word is not stored and state stays EMPTY (0-cycle latency).
//   - In EMPTY, o_vld=i_vld and o_dat=i_dat.
//   - i_rdy is still decoded from registered state only.
//   - flush in EMPTY with bypass still lets the passing word through (nothing is stored).
//  SIRV_SKID_BYPASS_EN undefined: behaviour exactly as in BEHAVIOUR (1-cycle latency, o_vld=0 in EMPTY).
// STRUCTURE
//  Shared package: state encoding localparams SKID_EMPTY=2'd0, SKID_ONE=2'd1, SKID_FULL=2'd2.
//  Sub-modules: main and skid data regs and the 2-bit state reg are sirv_gnrl_dfflr instances.
//   - Load enables are main_ld, skid_ld, state_ld.
//   - No other sub-module is instantiated.
// TESTING
//  1. Reset, then idle, DW=32: i_rdy=1, o_vld=0, o_cnt=0 from the first cycle.
//  2. Stream 0x1..0x8 with o_rdy=1 held high:
//     o_dat=0x1..0x8 on consecutive cycles, one cycle after each i_hs; o_cnt=1 throughout.
//  3. Push 0xA, 0xB with o_rdy=0: o_cnt=2 and i_rdy=0.
//     Raise o_rdy: 0xA then 0xB are delivered; i_rdy returns to 1 the cycle after the first o_hs.
//  4. Random i_vld/o_rdy over 10k words: scoreboard order matches; no loss or duplication.
//  5. FULL, then flush=1 for one cycle: next cycle o_vld=0, o_cnt=0, i_rdy=1.
//     A subsequent push of 0xC appears first at o_dat.
//  6. With SIRV_SKID_BYPASS_EN, EMPTY, i_vld=1, i_dat=0x55, o_rdy=1:
//     o_vld=1 and o_dat=0x55 in the same cycle; o_cnt stays 0.
//     Rerun 2–5 with the macro; all must pass.

Source files
------------

// File: rtl/sirv_gnrl_skid_buf_pkg.sv
// Shared types for the 2-entry skid buffer: state encoding and occupancy decode.
// Optional feature macro used by the buffer: SIRV_SKID_BYPASS_EN.
package sirv_gnrl_skid_buf_pkg;

    localparam int unsigned SKID_CNT_W = 2;

    typedef enum logic [SKID_CNT_W-1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    function automatic logic [SKID_CNT_W-1:0] skid_occ(input skid_state_e s);
        case (s)
            SKID_ONE:  skid_occ = 2'd1;
            SKID_FULL: skid_occ = 2'd2;
            default:   skid_occ = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sirv_gnrl_skid_buf_if.sv
// Valid/ready bus for the skid buffer: upstream (i_*) and downstream (o_*) sides plus occupancy.
interface sirv_gnrl_skid_buf_if #(
    parameter int unsigned DW = 32
);
    logic          i_vld;
    logic          i_rdy;
    logic [DW-1:0] i_dat;
    logic          o_vld;
    logic          o_rdy;
    logic [DW-1:0] o_dat;
    logic [1:0]    o_cnt;

    modport slave (
        input  i_vld, i_dat, o_rdy,
        output i_rdy, o_vld, o_dat, o_cnt
    );

    modport master (
        output i_vld, i_dat, o_rdy,
        input  i_rdy, o_vld, o_dat, o_cnt
    );
endinterface

// File: rtl/sirv_gnrl_dfflr.sv
// Load-enable flop bank with asynchronous active-low reset to zero.
module sirv_gnrl_dfflr #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/sirv_gnrl_skid_buf.sv
// 2-entry valid/ready skid buffer; i_rdy is decoded from registered state only.
// SIRV_SKID_BYPASS_EN: words pass combinationally through an empty buffer when o_rdy is high.
module sirv_gnrl_skid_buf
    import sirv_gnrl_skid_buf_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    sirv_gnrl_skid_buf_if.slave  bus
);

    logic [SKID_CNT_W-1:0] state_q;
    skid_state_e           state;
    skid_state_e           state_nxt;
    logic                  state_ld;

    logic [DW-1:0] main_q;
    logic [DW-1:0] main_nxt;
    logic          main_ld;
    logic [DW-1:0] skid_q;
    logic          skid_ld;

    logic i_rdy;
    logic o_vld;
    logic i_hs;
    logic o_hs;

    assign state = skid_state_e'(state_q);

    assign i_rdy = (state != SKID_FULL);
    assign i_hs  = bus.i_vld & i_rdy;
    assign o_hs  = o_vld & bus.o_rdy;

`ifdef SIRV_SKID_BYPASS_EN
    assign o_vld     = (state == SKID_EMPTY) ? bus.i_vld : 1'b1;
    assign bus.o_dat = (state == SKID_EMPTY) ? bus.i_dat : main_q;
`else
    assign o_vld     = (state != SKID_EMPTY);
    assign bus.o_dat = main_q;
`endif

    assign bus.i_rdy = i_rdy;
    assign bus.o_vld = o_vld;
    assign bus.o_cnt = skid_occ(state);

    // o_hs in EMPTY only occurs as a bypass pass-through; that word is never stored.
    always_comb begin
        state_nxt = state;
        main_ld   = 1'b0;
        skid_ld   = 1'b0;
        main_nxt  = bus.i_dat;
        case (state)
            SKID_EMPTY: begin
                if (i_hs && !o_hs) begin
                    main_ld   = 1'b1;
                    state_nxt = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (i_hs && o_hs) begin
                    main_ld = 1'b1;
                end else if (i_hs) begin
                    skid_ld   = 1'b1;
                    state_nxt = SKID_FULL;
                end else if (o_hs) begin
                    state_nxt = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (o_hs) begin
                    main_ld   = 1'b1;
                    main_nxt  = skid_q;
                    state_nxt = SKID_ONE;
                end
            end
            default: begin
                state_nxt = SKID_EMPTY;
            end
        endcase
        if (flush) begin
            main_ld   = 1'b0;
            skid_ld   = 1'b0;
            state_nxt = SKID_EMPTY;
        end
    end

    assign state_ld = (state_nxt != state);

    sirv_gnrl_dfflr #(.DW(SKID_CNT_W)) u_state_dfflr (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (state_ld),
        .dnxt  (state_nxt),
        .qout  (state_q)
    );

    sirv_gnrl_dfflr #(.DW(DW)) u_main_dfflr (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (main_ld),
        .dnxt  (main_nxt),
        .qout  (main_q)
    );

    sirv_gnrl_dfflr #(.DW(DW)) u_skid_dfflr (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (skid_ld),
        .dnxt  (bus.i_dat),
        .qout  (skid_q)
    );

endmodule

// File: tb/tb_sirv_gnrl_skid_buf.sv
// Self-checking bench for sirv_gnrl_skid_buf: scenario tasks plus a scoreboard monitor.
module tb_sirv_gnrl_skid_buf;

    logic clk;
    logic rst_n;
    logic flush;
    int   nvec;
    int   nerr;
    int   nrecv;
    logic [31:0] sb_q[$];

    sirv_gnrl_skid_buf_if #(.DW(32)) bus ();

    sirv_gnrl_skid_buf #(.DW(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: push on i_hs, pop and compare on o_hs, discard on flush; also checks
    // occupancy-derived outputs against the queue depth every cycle.
    always @(negedge clk) begin
        logic        exp_vld;
        logic [31:0] exp_dat;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
`ifdef SIRV_SKID_BYPASS_EN
            exp_vld = (sb_q.size() != 0) || bus.i_vld;
`else
            exp_vld = (sb_q.size() != 0);
`endif
            nvec++;
            if (bus.o_cnt !== 2'(sb_q.size())) begin
                nerr++;
                $display("FAIL sb_cnt: got %0d expected %0d at %0t", bus.o_cnt, sb_q.size(), $time);
            end
            nvec++;
            if (bus.i_rdy !== (sb_q.size() != 2)) begin
                nerr++;
                $display("FAIL sb_i_rdy: got %b expected %b at %0t", bus.i_rdy, sb_q.size() != 2, $time);
            end
            nvec++;
            if (bus.o_vld !== exp_vld) begin
                nerr++;
                $display("FAIL sb_o_vld: got %b expected %b at %0t", bus.o_vld, exp_vld, $time);
            end
            if (bus.i_vld && bus.i_rdy) sb_q.push_back(bus.i_dat);
            if (bus.o_vld && bus.o_rdy) begin
                nvec++;
                nrecv++;
                if (sb_q.size() == 0) begin
                    nerr++;
                    $display("FAIL sb_dup: o_hs with data %h, expected no word at %0t", bus.o_dat, $time);
                end else begin
                    exp_dat = sb_q.pop_front();
                    if (bus.o_dat !== exp_dat) begin
                        nerr++;
                        $display("FAIL sb_data: got %h expected %h at %0t", bus.o_dat, exp_dat, $time);
                    end
                end
            end
            if (flush) sb_q.delete();
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        bus.i_vld = 1'b0;
        bus.i_dat = '0;
        bus.o_rdy = 1'b0;
        #2;
        nvec++;
        if (bus.i_rdy !== 1'b1 || bus.o_vld !== 1'b0 || bus.o_cnt !== 2'd0 || bus.o_dat !== 32'h0) begin
            nerr++;
            $display("FAIL reset: got i_rdy=%b o_vld=%b o_cnt=%0d o_dat=%h expected 1 0 0 0",
                     bus.i_rdy, bus.o_vld, bus.o_cnt, bus.o_dat);
        end
        #10 rst_n = 1'b1;
        tick();
        tick();
        nvec++;
        if (bus.i_rdy !== 1'b1 || bus.o_vld !== 1'b0 || bus.o_cnt !== 2'd0) begin
            nerr++;
            $display("FAIL idle: got i_rdy=%b o_vld=%b o_cnt=%0d expected 1 0 0",
                     bus.i_rdy, bus.o_vld, bus.o_cnt);
        end
    endtask

    task automatic test_stream();
        logic [1:0] exp_cnt;
`ifdef SIRV_SKID_BYPASS_EN
        exp_cnt = 2'd0;
`else
        exp_cnt = 2'd1;
`endif
        bus.o_rdy = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            bus.i_vld = 1'b1;
            bus.i_dat = 32'(k);
            tick();
            nvec++;
            if (bus.o_vld !== 1'b1 || bus.o_dat !== 32'(k) || bus.o_cnt !== exp_cnt) begin
                nerr++;
                $display("FAIL stream: got o_vld=%b o_dat=%h o_cnt=%0d expected 1 %h %0d",
                         bus.o_vld, bus.o_dat, bus.o_cnt, 32'(k), exp_cnt);
            end
        end
        bus.i_vld = 1'b0;
        tick();
        nvec++;
        if (bus.o_cnt !== 2'd0 || bus.o_vld !== 1'b0) begin
            nerr++;
            $display("FAIL stream_end: got o_cnt=%0d o_vld=%b expected 0 0", bus.o_cnt, bus.o_vld);
        end
    endtask

    task automatic test_full();
        bus.o_rdy = 1'b0;
        bus.i_vld = 1'b1;
        bus.i_dat = 32'hA;
        tick();
        bus.i_dat = 32'hB;
        tick();
        bus.i_vld = 1'b0;
        #1;
        nvec++;
        if (bus.o_cnt !== 2'd2 || bus.i_rdy !== 1'b0 || bus.o_dat !== 32'hA) begin
            nerr++;
            $display("FAIL full: got o_cnt=%0d i_rdy=%b o_dat=%h expected 2 0 a",
                     bus.o_cnt, bus.i_rdy, bus.o_dat);
        end
        bus.o_rdy = 1'b1;
        tick();
        nvec++;
        if (bus.o_dat !== 32'hB || bus.i_rdy !== 1'b1 || bus.o_cnt !== 2'd1) begin
            nerr++;
            $display("FAIL drain: got o_dat=%h i_rdy=%b o_cnt=%0d expected b 1 1",
                     bus.o_dat, bus.i_rdy, bus.o_cnt);
        end
        tick();
        nvec++;
        if (bus.o_cnt !== 2'd0) begin
            nerr++;
            $display("FAIL drain_end: got o_cnt=%0d expected 0", bus.o_cnt);
        end
    endtask

    task automatic test_flush();
        bus.o_rdy = 1'b0;
        bus.i_vld = 1'b1;
        bus.i_dat = 32'h11;
        tick();
        bus.i_dat = 32'h22;
        tick();
        flush     = 1'b1;
        bus.i_dat = 32'h33;
        tick();
        flush     = 1'b0;
        bus.i_vld = 1'b0;
        #1;
        nvec++;
        if (bus.o_vld !== 1'b0 || bus.o_cnt !== 2'd0 || bus.i_rdy !== 1'b1) begin
            nerr++;
            $display("FAIL flush: got o_vld=%b o_cnt=%0d i_rdy=%b expected 0 0 1",
                     bus.o_vld, bus.o_cnt, bus.i_rdy);
        end
        bus.i_vld = 1'b1;
        bus.i_dat = 32'hC;
        tick();
        bus.i_vld = 1'b0;
        #1;
        nvec++;
        if (bus.o_vld !== 1'b1 || bus.o_dat !== 32'hC) begin
            nerr++;
            $display("FAIL flush_push: got o_vld=%b o_dat=%h expected 1 c", bus.o_vld, bus.o_dat);
        end
        // flush in ONE while both handshakes fire: output word leaves, input word is dropped
        bus.o_rdy = 1'b1;
        bus.i_vld = 1'b1;
        bus.i_dat = 32'h45;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        bus.i_vld = 1'b0;
        #1;
        nvec++;
        if (bus.o_cnt !== 2'd0 || bus.o_vld !== 1'b0) begin
            nerr++;
            $display("FAIL flush_one: got o_cnt=%0d o_vld=%b expected 0 0", bus.o_cnt, bus.o_vld);
        end
    endtask

    task automatic test_async_reset();
        bus.o_rdy = 1'b0;
        bus.i_vld = 1'b1;
        bus.i_dat = 32'h77;
        tick();
        bus.i_vld = 1'b0;
        #1;
        nvec++;
        if (bus.o_vld !== 1'b1) begin
            nerr++;
            $display("FAIL pre_areset: got o_vld=%b expected 1", bus.o_vld);
        end
        #1 rst_n = 1'b0;
        #1;
        nvec++;
        if (bus.o_vld !== 1'b0 || bus.o_cnt !== 2'd0 || bus.i_rdy !== 1'b1) begin
            nerr++;
            $display("FAIL areset: got o_vld=%b o_cnt=%0d i_rdy=%b expected 0 0 1",
                     bus.o_vld, bus.o_cnt, bus.i_rdy);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int   sent;
        int   cyc;
        logic hs;
        sent      = 0;
        cyc       = 0;
        nrecv     = 0;
        flush     = 1'b0;
        bus.i_vld = 1'b0;
        while ((sent < 10000 || sb_q.size() != 0) && cyc < 60000) begin
            @(negedge clk);
            hs = bus.i_vld & bus.i_rdy;
            tick();
            cyc++;
            if (hs) sent++;
            if (!bus.i_vld || hs) begin
                if (sent < 10000 && $urandom_range(0, 9) < 7) begin
                    bus.i_vld = 1'b1;
                    bus.i_dat = $urandom;
                end else begin
                    bus.i_vld = 1'b0;
                end
            end
            bus.o_rdy = ($urandom_range(0, 9) < 6);
        end
        bus.i_vld = 1'b0;
        bus.o_rdy = 1'b0;
        nvec++;
        if (nrecv !== 10000 || cyc >= 60000) begin
            nerr++;
            $display("FAIL random: got %0d words in %0d cycles expected 10000 within 60000", nrecv, cyc);
        end
        tick();
    endtask

`ifdef SIRV_SKID_BYPASS_EN
    task automatic test_bypass();
        bus.o_rdy = 1'b1;
        bus.i_vld = 1'b1;
        bus.i_dat = 32'h55;
        #1;
        nvec++;
        if (bus.o_vld !== 1'b1 || bus.o_dat !== 32'h55 || bus.o_cnt !== 2'd0) begin
            nerr++;
            $display("FAIL bypass: got o_vld=%b o_dat=%h o_cnt=%0d expected 1 55 0",
                     bus.o_vld, bus.o_dat, bus.o_cnt);
        end
        tick();
        bus.i_vld = 1'b0;
        #1;
        nvec++;
        if (bus.o_cnt !== 2'd0 || bus.o_vld !== 1'b0) begin
            nerr++;
            $display("FAIL bypass_store: got o_cnt=%0d o_vld=%b expected 0 0", bus.o_cnt, bus.o_vld);
        end
        flush     = 1'b1;
        bus.i_vld = 1'b1;
        bus.i_dat = 32'h66;
        #1;
        nvec++;
        if (bus.o_vld !== 1'b1 || bus.o_dat !== 32'h66) begin
            nerr++;
            $display("FAIL bypass_flush: got o_vld=%b o_dat=%h expected 1 66", bus.o_vld, bus.o_dat);
        end
        tick();
        flush     = 1'b0;
        bus.i_vld = 1'b0;
        tick();
    endtask
`endif

    initial begin
        nvec  = 0;
        nerr  = 0;
        nrecv = 0;
        test_reset();
`ifdef SIRV_SKID_BYPASS_EN
        test_bypass();
`endif
        test_stream();
        test_full();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
